// File: rtl/arbiter_pkg.sv
// arbiter_pkg: implementation selectors shared by the arbiter and its one-hot encoder.
`default_nettype none

package arbiter_pkg;
  localparam int IMPL_TABLE = 0;
  localparam int IMPL_LOOP  = 1;
endpackage

`default_nettype wire

// File: rtl/onehot_encoder_base.sv
// onehot_encoder_base: one-hot to binary index encoder, table (OR-mask) or loop form.
`default_nettype none

module onehot_encoder_base
  import arbiter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = IMPL_TABLE,
  localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 enc_vld
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "onehot_encoder_base: WIDTH must be >= 2");
  end

  assign enc_vld = |oht;

  if (IMPLEMENTATION == IMPL_TABLE) begin : g_table
    // Index bit b is the OR of every one-hot position whose index has bit b set.
    for (genvar b = 0; b < WIDTH_LOG; b++) begin : g_bit
      logic [WIDTH-1:0] sel;
      for (genvar i = 0; i < WIDTH; i++) begin : g_sel
        assign sel[i] = ((i >> b) & 1) != 0;
      end
      assign idx[b] = |(oht & sel);
    end
  end else if (IMPLEMENTATION == IMPL_LOOP) begin : g_loop
    always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (oht[i]) idx = idx | WIDTH_LOG'(i);
      end
    end
  end else begin : g_bad_impl
    $fatal(1, "onehot_encoder_base: IMPLEMENTATION must be 0 or 1");
  end

endmodule

`default_nettype wire

// File: rtl/arbiter_round_robin.sv
// arbiter_round_robin: pointer-based round-robin arbiter with registered one-hot grant
// held under a valid/ready handshake.
`default_nettype none

module arbiter_round_robin
  import arbiter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = IMPL_TABLE,
  localparam int WIDTH_LOG     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "arbiter_round_robin: WIDTH must be >= 2");
  end

  logic [WIDTH_LOG-1:0] ptr;
  logic                 transfer;
  logic [WIDTH-1:0]     cand;
  logic [WIDTH-1:0]     mask;
  logic [WIDTH-1:0]     masked;
  logic [WIDTH-1:0]     pick;
  logic [WIDTH-1:0]     nxt_oht;
  logic [WIDTH_LOG-1:0] nxt_idx;
  logic                 nxt_vld;

  assign transfer = gnt_vld & gnt_rdy;
  // The requester leaving this cycle must not win again in the same decision.
  assign cand     = req & ~(transfer ? gnt_oht : '0);

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  assign masked  = cand & mask;
  assign pick    = (|masked) ? masked : cand;
  assign nxt_oht = pick & (-pick);

  onehot_encoder_base #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_enc (
    .oht     (nxt_oht),
    .idx     (nxt_idx),
    .enc_vld (nxt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_oht <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr     <= '0;
    end else begin
      // Grant is locked while valid and not accepted; otherwise re-arbitrate.
      if (!gnt_vld || transfer) begin
        gnt_oht <= nxt_oht;
        gnt_idx <= nxt_idx;
        gnt_vld <= nxt_vld;
      end
      if (transfer) begin
        ptr <= (gnt_idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbiter_round_robin.sv
// tb_arbiter_round_robin: directed scoreboard bench for a 4-requester arbiter.
`default_nettype none

module tb_arbiter_round_robin;

  localparam int W = 4;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] oht;
    logic [1:0]   idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req = '0;
  logic         gnt_rdy = 1'b0;
  logic [W-1:0] gnt_oht;
  logic [1:0]   gnt_idx;
  logic         gnt_vld;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  arbiter_round_robin #(
    .WIDTH          (W),
    .IMPLEMENTATION (0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt_oht (gnt_oht),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (gnt_vld === e.vld && gnt_oht === e.oht && gnt_idx === e.idx) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got vld=%b oht=%b idx=%0d, expected vld=%b oht=%b idx=%0d",
               name, gnt_vld, gnt_oht, gnt_idx, e.vld, e.oht, e.idx);
    end
  endtask

  // Monitor: pops one expectation per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        cyc++;
        check($sformatf("cycle%0d", cyc), e);
      end
    end
  end

  // Drive inputs, then queue the outputs expected after the coming edge.
  task automatic step(input logic [W-1:0] r, input logic rdy,
                      input logic ev, input logic [W-1:0] eo, input logic [1:0] ei);
    req     = r;
    gnt_rdy = rdy;
    @(posedge clk);
    sb.push_back('{vld: ev, oht: eo, idx: ei});
    #1;
  endtask

  initial begin
    // Reset held with all requesting
    step(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
    step(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);

    // Fairness rotation 0,1,2,3,0,1
    step(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);
    step(4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2);
    step(4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
    step(4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
    step(4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);

    // Backpressure lock on idx1, request change ignored, then accept
    step(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    step(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    step(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    step(4'b0100, 1'b0, 1'b1, 4'b0010, 2'd1);
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);

    // Wrap: ptr=3 -> idx3, then idx0, then ptr=1 proven by idle re-arbitration
    step(4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3);
    step(4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0);
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    step(4'b0011, 1'b0, 1'b1, 4'b0010, 2'd1);

    // Single persistent requester under continuous ready
    step(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0);
    step(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0);
    step(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0);
    step(4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0);

    // Async reset while granting idx2
    step(4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
    step(4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", '{vld: 1'b0, oht: 4'b0000, idx: 2'd0});
    step(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
